// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload responder.
// Holds the FSM state encoding and the fixed reply words used on error paths.
package ioctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DRAIN
  } state_t;

  localparam logic [15:0] DIN_TIMEOUT      = 16'hDEAD;
  localparam logic [15:0] DIN_OUT_OF_RANGE = 16'hFFFF;

  function automatic logic [15:0] swap_bytes(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/ioctl_upload_responder_if.sv
// Bundle of the hps_io ioctl read side and the backing-memory read port.
// slave = the responder; master = whoever drives ioctl and models memory.
interface ioctl_upload_responder_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  ioctl_upload;
  logic [7:0]            ioctl_index;
  logic                  ioctl_rd;
  logic [26:0]           ioctl_addr;
  logic [15:0]           ioctl_din;
  logic                  ioctl_wait;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_waitReq;
  logic                  mem_valid;
  logic [15:0]           mem_dout;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  mem_waitReq, mem_valid, mem_dout,
    output ioctl_din, ioctl_wait, mem_rd, mem_addr
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output mem_waitReq, mem_valid, mem_dout,
    input  ioctl_din, ioctl_wait, mem_rd, mem_addr
  );
endinterface

// File: rtl/ioctl_upload_responder.sv
// Serves HPS upload reads (e.g. NVRAM save) from a 16-bit word memory,
// stalling hps_io with ioctl_wait until the data is ready or a timeout fires.
module ioctl_upload_responder
  import ioctl_pkg::*;
#(
  parameter logic [7:0] INDEX      = 8'h04,
  parameter int         ADDR_WIDTH = 15,
  parameter int         TIMEOUT    = 255,
  parameter bit         SWAP       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  ioctl_upload_responder_if.slave  bus,
  output logic [15:0]              words,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [15:0]           din_q, din_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           cnt_q;
  logic                  active, active_q, rd_acc, out_of_range, tmo_hit;
  logic                  latch_addr, load_din, inc_words, set_tmo, set_ovr, wait_c;
  logic                  unused_addr_lsb;

  assign active          = bus.ioctl_upload && (bus.ioctl_index == INDEX);
  assign rd_acc          = active && bus.ioctl_rd;
  assign out_of_range    = |bus.ioctl_addr[26:ADDR_WIDTH+1];
  assign tmo_hit         = (cnt_q == TMO_LAST);
  assign unused_addr_lsb = bus.ioctl_addr[0];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    latch_addr = 1'b0;
    load_din   = 1'b0;
    inc_words  = 1'b0;
    set_tmo    = 1'b0;
    set_ovr    = 1'b0;
    wait_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_acc) begin
          wait_c = 1'b1;
          if (out_of_range) begin
            load_din = 1'b1;
            din_d    = DIN_OUT_OF_RANGE;
          end else begin
            latch_addr = 1'b1;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        wait_c = 1'b1;
        if (!active) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          // A request taken in the timeout cycle will still return data.
          load_din = 1'b1;
          din_d    = DIN_TIMEOUT;
          set_tmo  = 1'b1;
          state_d  = bus.mem_waitReq ? ST_IDLE : ST_DRAIN;
        end else if (!bus.mem_waitReq) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        wait_c = 1'b1;
        if (bus.mem_valid) begin
          if (active) begin
            load_din  = 1'b1;
            din_d     = SWAP ? swap_bytes(bus.mem_dout) : bus.mem_dout;
            inc_words = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (!active) begin
          state_d = ST_DRAIN;
        end else if (tmo_hit) begin
          load_din = 1'b1;
          din_d    = DIN_TIMEOUT;
          set_tmo  = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_acc && (state_q != ST_IDLE)) set_ovr = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      words       <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      active_q <= active;
      if (load_din)   din_q  <= din_d;
      if (latch_addr) addr_q <= bus.ioctl_addr[ADDR_WIDTH:1];
      if (latch_addr)
        cnt_q <= '0;
      else if (state_q == ST_REQ || state_q == ST_RESP)
        cnt_q <= cnt_q + 16'd1;
      // New session clears status; a same-cycle error still gets recorded.
      if (active && !active_q) begin
        words       <= '0;
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end else if (inc_words) begin
        words <= words + 16'd1;
      end
      if (set_tmo) err_timeout <= 1'b1;
      if (set_ovr) err_overrun <= 1'b1;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_c;
  assign bus.mem_rd     = (state_q == ST_REQ) && active;
  assign bus.mem_addr   = addr_q;

endmodule
